// File: rtl/la_sa_sequencer_pkg.sv
// sa_ctrl_pkg: shared definitions for the systolic-array command sequencer.
//   - LA command opcodes
//   - sequencer FSM state encoding
//   - operand-buffer layout (weight rows first, activations after them)
//   - small width helper shared by the interface and the top level
package sa_ctrl_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_LOAD_W = 2'b01;
    localparam logic [1:0] OP_RUN    = 2'b10;
    localparam logic [1:0] OP_ABORT  = 2'b11;

    localparam int LEN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LTAIL  = 3'd2,
        ST_CLR    = 3'd3,
        ST_STREAM = 3'd4,
        ST_DRAIN  = 3'd5
    } state_e;

    // Weight rows live at the bottom of the operand buffer.
    localparam int W_BASE = 0;

    // Activation vectors start directly after the N weight rows.
    function automatic int a_base(input int n);
        return W_BASE + n;
    endfunction

    // Row index width; a 1x1 array still gets a 1-bit row field.
    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/la_sa_sequencer_if.sv
// la_sa_sequencer_if: LA command/status and operand-buffer/array strobes.
//   master : firmware / LA side (drives command, observes everything else)
//   slave  : sequencer side (receives command, drives buffer, array and status)
// Signals:
//   la_cmd_strobe, la_cmd_op[1:0], la_cmd_len[7:0]   command from LA
//   buf_rd_en, buf_rd_addr[ADDR_W-1:0]                operand-buffer read
//   sa_w_load, sa_w_row, sa_clear, sa_a_valid,
//   sa_out_capture                                    array control
//   busy, done, err, w_loaded, cyc_cnt[15:0]          status back to LA
interface la_sa_sequencer_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 8
);
    import sa_ctrl_pkg::*;

    localparam int ROW_W = row_width(N);

    logic              la_cmd_strobe;
    logic [1:0]        la_cmd_op;
    logic [LEN_W-1:0]  la_cmd_len;

    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic              sa_w_load;
    logic [ROW_W-1:0]  sa_w_row;
    logic              sa_clear;
    logic              sa_a_valid;
    logic              sa_out_capture;

    logic              busy;
    logic              done;
    logic              err;
    logic              w_loaded;
    logic [15:0]       cyc_cnt;

    modport master (
        output la_cmd_strobe, la_cmd_op, la_cmd_len,
        input  buf_rd_en, buf_rd_addr, sa_w_load, sa_w_row, sa_clear,
               sa_a_valid, sa_out_capture, busy, done, err, w_loaded, cyc_cnt
    );

    modport slave (
        input  la_cmd_strobe, la_cmd_op, la_cmd_len,
        output buf_rd_en, buf_rd_addr, sa_w_load, sa_w_row, sa_clear,
               sa_a_valid, sa_out_capture, busy, done, err, w_loaded, cyc_cnt
    );

endinterface

// File: rtl/la_sa_sequencer_out_window.sv
// sa_out_window: result-capture window for a RUN.
//   Delays the activation-valid strobe by OUT_LAT cycles to mark valid
//   result columns, and counts captures down from the RUN length.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   a_valid_i       activation vector entered the array this cycle
//   flush_i         abort: drop everything in flight
//   load_i, len_i   RUN accepted, K activation vectors expected
//   capture_o       result column valid this cycle
//   drain_done_o    this capture is the K-th one
module sa_out_window
    import sa_ctrl_pkg::*;
#(
    parameter int OUT_LAT = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_valid_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             capture_o,
    output logic             drain_done_o
);

    logic [OUT_LAT-1:0] dly_q;
    logic [LEN_W-1:0]   remain_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            dly_q    <= '0;
            remain_q <= '0;
        end else begin
            dly_q[0] <= a_valid_i;
            for (int i = 1; i < OUT_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
            if (load_i) begin
                remain_q <= len_i;
            end else if (capture_o && (remain_q != '0)) begin
                remain_q <= remain_q - LEN_W'(1);
            end
        end
    end

    assign capture_o    = dly_q[OUT_LAT-1];
    assign drain_done_o = capture_o && (remain_q == LEN_W'(1));

endmodule

// File: rtl/la_sa_sequencer.sv
// la_sa_sequencer: LA-driven command sequencer for the systolic array.
//   Edge-detects la_cmd_strobe, runs LOAD_W (weight rows into the array)
//   and RUN (clear, stream K activations, wait for K result columns), and
//   keeps busy/done/err/w_loaded/cyc_cnt status for firmware polling.
// Ports:
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset
//   sa_bus     la_sa_sequencer_if slave: command in, buffer/array/status out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a command
// ST_LOAD   | reading weight rows 0..N-1 from the buffer
// ST_LTAIL  | last weight row being latched by the array
// ST_CLR    | one-cycle accumulator clear
// ST_STREAM | reading K activation vectors from the buffer
// ST_DRAIN  | waiting for the K-th result column
module la_sa_sequencer
    import sa_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int ADDR_W  = 8,
    parameter int OUT_LAT = 2 * N - 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    la_sa_sequencer_if.slave sa_bus
);

    localparam int          ROW_W = row_width(N);
    localparam logic [31:0] K_MAX = 32'((1 << ADDR_W) - N);

    state_e            state_q, state_d;
    logic              strobe_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              w_load_q;
    logic [ROW_W-1:0]  w_row_q;
    logic              a_valid_q;
    logic              done_q;
    logic              err_q;
    logic              w_loaded_q;
    logic [15:0]       cyc_cnt_q;

    logic busy;
    logic rise;
    logic cmd_abort;
    logic cmd_ignored;
    logic acc_load;
    logic run_req;
    logic len_ok;
    logic run_ok;
    logic run_rej;
    logic finish;
    logic capture;
    logic drain_done;

    assign busy        = (state_q != ST_IDLE);
    assign rise        = sa_bus.la_cmd_strobe & ~strobe_q;
    assign cmd_abort   = rise && busy && (sa_bus.la_cmd_op == OP_ABORT);
    assign cmd_ignored = rise && busy &&
                         ((sa_bus.la_cmd_op == OP_LOAD_W) || (sa_bus.la_cmd_op == OP_RUN));
    assign acc_load    = rise && !busy && (sa_bus.la_cmd_op == OP_LOAD_W);
    assign run_req     = rise && !busy && (sa_bus.la_cmd_op == OP_RUN);
    // Upper bound keeps the last activation address inside the buffer.
    assign len_ok      = (sa_bus.la_cmd_len != '0) && (32'(sa_bus.la_cmd_len) <= K_MAX);
    assign run_ok      = run_req && len_ok && w_loaded_q;
    assign run_rej     = run_req && !run_ok;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_load) begin
                    state_d  = ST_LOAD;
                    addr_d   = ADDR_W'(W_BASE);
                    remain_d = LEN_W'(N - 1);
                end else if (run_ok) begin
                    state_d  = ST_CLR;
                    addr_d   = ADDR_W'(a_base(N));
                    remain_d = sa_bus.la_cmd_len - LEN_W'(1);
                end
            end
            ST_LOAD: begin
                if (remain_q == '0) begin
                    state_d = ST_LTAIL;
                end else begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                end
            end
            ST_LTAIL: begin
                state_d = ST_IDLE;
                finish  = 1'b1;
            end
            ST_CLR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (remain_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Abort beats a completion landing in the same cycle.
        if (cmd_abort) begin
            state_d = ST_IDLE;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            w_load_q   <= 1'b0;
            w_row_q    <= '0;
            a_valid_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            w_loaded_q <= 1'b0;
            cyc_cnt_q  <= '0;
            // Track the live strobe level so a strobe already high when
            // reset releases is not seen as a new command.
            strobe_q   <= sa_bus.la_cmd_strobe;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            strobe_q  <= sa_bus.la_cmd_strobe;

            // Buffer data returns one cycle after the read; an abort drops it.
            w_load_q  <= (state_q == ST_LOAD) && !cmd_abort;
            w_row_q   <= ROW_W'(addr_q - ADDR_W'(W_BASE));
            a_valid_q <= (state_q == ST_STREAM) && !cmd_abort;

            if (acc_load || run_ok) begin
                done_q <= 1'b0;
            end else if (finish) begin
                done_q <= 1'b1;
            end

            if (run_rej || cmd_ignored) begin
                err_q <= 1'b1;
            end

            if (finish && (state_q == ST_LTAIL)) begin
                w_loaded_q <= 1'b1;
            end else if (cmd_abort && ((state_q == ST_LOAD) || (state_q == ST_LTAIL))) begin
                w_loaded_q <= 1'b0;
            end

            if (acc_load || run_ok) begin
                cyc_cnt_q <= '0;
            end else if (busy && (cyc_cnt_q != 16'hFFFF)) begin
                cyc_cnt_q <= cyc_cnt_q + 16'd1;
            end
        end
    end

    sa_out_window #(
        .OUT_LAT (OUT_LAT)
    ) u_out_window (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .a_valid_i    (a_valid_q),
        .flush_i      (cmd_abort),
        .load_i       (run_ok),
        .len_i        (sa_bus.la_cmd_len),
        .capture_o    (capture),
        .drain_done_o (drain_done)
    );

    assign sa_bus.buf_rd_en      = (state_q == ST_LOAD) || (state_q == ST_STREAM);
    assign sa_bus.buf_rd_addr    = sa_bus.buf_rd_en ? addr_q : '0;
    assign sa_bus.sa_w_load      = w_load_q;
    assign sa_bus.sa_w_row       = w_load_q ? w_row_q : '0;
    assign sa_bus.sa_clear       = (state_q == ST_CLR);
    assign sa_bus.sa_a_valid     = a_valid_q;
    assign sa_bus.sa_out_capture = capture;
    assign sa_bus.busy           = busy;
    assign sa_bus.done           = done_q;
    assign sa_bus.err            = err_q;
    assign sa_bus.w_loaded       = w_loaded_q;
    assign sa_bus.cyc_cnt        = cyc_cnt_q;

endmodule
